draw_unit_gen: RTL and testbench

Parametrised successor of the primitive draw dispatcher. It accepts one primitive command through a valid/ready handshake and latches it. It then rasterises the command into a stream of pixel coordinates, one pixel per cycle, with back-pressure. It sits between the command decoder and the framebuffer write port. It supports point, Bresenham line, rectangle outline and filled rectangle, plus abort and an unsupported-type error report.

---
 rtl/draw_unit_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_draw_unit_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_unit_gen.sv
// Primitive rasteriser: latches one draw command and streams its pixels
// (point, Bresenham line, rectangle outline/fill) one per cycle with back-pressure.
module draw_unit_gen #(
  parameter int unsigned CW = 8,
  parameter int unsigned TW = 8
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          ENB,
  input  logic          ABORT,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [TW-1:0] TYPE,
  input  logic [CW-1:0] X_0,
  input  logic [CW-1:0] Y_0,
  input  logic [CW-1:0] X_1,
  input  logic [CW-1:0] Y_1,
  output logic          PIX_VALID,
  input  logic          PIX_READY,
  output logic [CW-1:0] X_OUT,
  output logic [CW-1:0] Y_OUT,
  output logic          PIX_LAST,
  output logic          BUSY,
  output logic          FINISH,
  output logic          ERR
);

  localparam int unsigned EW = CW + 2;
  localparam int unsigned KW = TW - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
  typedef enum logic [1:0] {K_LINE = 2'd0, K_POINT = 2'd1, K_OUTL = 2'd2, K_FILL = 2'd3} kind_t;

  state_t               state_q;
  kind_t                kind_q;
  logic [CW-1:0]        x_q, y_q;
  logic [CW-1:0]        xmin_q, xmax_q, ymin_q, ymax_q;
  logic [CW-1:0]        xe_q, ye_q;
  logic [1:0]           edge_q;
  logic                 sx_q, sy_q;
  logic signed [EW-1:0] dx_q, dy_q, bres_q;
  logic                 rdy_q, pv_q, last_q, busy_q, fin_q, err_q;

  // Command decode on the raw inputs, used only in the accept cycle
  logic [KW-1:0]        code;
  logic                 in_sup, in_edges, in_line_last, in_rect_last;
  kind_t                in_kind;
  logic [CW-1:0]        in_xmin, in_xmax, in_ymin, in_ymax, adx, ady;
  logic signed [EW-1:0] in_dx, in_dy;
  logic                 unused_type_bits;

  assign unused_type_bits = ^TYPE[1:0];

  always_comb begin
    code         = TYPE[TW-1:2];
    in_sup       = (code <= KW'(3));
    in_xmin      = (X_0 <= X_1) ? X_0 : X_1;
    in_xmax      = (X_0 <= X_1) ? X_1 : X_0;
    in_ymin      = (Y_0 <= Y_1) ? Y_0 : Y_1;
    in_ymax      = (Y_0 <= Y_1) ? Y_1 : Y_0;
    adx          = in_xmax - in_xmin;
    ady          = in_ymax - in_ymin;
    in_dx        = $signed({2'b00, adx});
    in_dy        = -$signed({2'b00, ady});
    in_line_last = (X_0 == X_1) && (Y_0 == Y_1);
    in_rect_last = (in_xmin == in_xmax) && (in_ymin == in_ymax);
    in_edges     = (in_xmin != in_xmax) && (in_ymin != in_ymax);
    in_kind      = K_LINE;
    if (code == KW'(1))      in_kind = K_POINT;
    else if (code == KW'(2)) in_kind = in_edges ? K_OUTL : K_FILL;  // 1-wide outline == fill
    else if (code == KW'(3)) in_kind = K_FILL;
  end

  // Next pixel after the current one is handed over
  logic [CW-1:0]        nx, ny;
  logic [1:0]           ne;
  logic                 nlast, step_x, step_y, h_is_2;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic signed [EW-1:0] nbres, add_x, add_y;

  always_comb begin
    nx     = x_q;
    ny     = y_q;
    ne     = edge_q;
    nlast  = 1'b0;
    e2     = $signed({bres_q, 1'b0});
    dx_w   = $signed({dx_q[EW-1], dx_q});
    dy_w   = $signed({dy_q[EW-1], dy_q});
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    add_x  = step_x ? dy_q : '0;
    add_y  = step_y ? dx_q : '0;
    nbres  = bres_q + add_x + add_y;
    h_is_2 = (({1'b0, ymin_q} + (CW+1)'(1)) == {1'b0, ymax_q});
    case (kind_q)
      K_LINE: begin
        if (step_x) nx = sx_q ? x_q + CW'(1) : x_q - CW'(1);
        if (step_y) ny = sy_q ? y_q + CW'(1) : y_q - CW'(1);
        nlast = (nx == xe_q) && (ny == ye_q);
      end
      K_FILL: begin
        if (x_q == xmax_q) begin
          nx = xmin_q;
          ny = y_q + CW'(1);
        end else begin
          nx = x_q + CW'(1);
        end
        nlast = (nx == xmax_q) && (ny == ymax_q);
      end
      K_OUTL: begin
        case (edge_q)
          2'd0: if (x_q == xmax_q) begin ne = 2'd1; ny = y_q + CW'(1); end
                else nx = x_q + CW'(1);
          2'd1: if (y_q == ymax_q) begin ne = 2'd2; nx = x_q - CW'(1); end
                else ny = y_q + CW'(1);
          2'd2: if (x_q == xmin_q) begin ne = 2'd3; ny = y_q - CW'(1); end
                else nx = x_q - CW'(1);
          default: ny = y_q - CW'(1);
        endcase
        nlast = ((ne == 2'd2) && (nx == xmin_q) && h_is_2) ||
                ((ne == 2'd3) && (ny == ymin_q + CW'(1)));
      end
      default: nlast = 1'b1;
    endcase
  end

  // Control FSM and pixel registers; ENB low freezes everything
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      kind_q  <= K_LINE;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      edge_q  <= 2'd0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      bres_q  <= '0;
      rdy_q   <= 1'b1;
      pv_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (ENB) begin
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID) begin
            rdy_q <= 1'b0;
            if (in_sup) begin
              state_q <= S_RUN;
              kind_q  <= in_kind;
              xmin_q  <= in_xmin;
              xmax_q  <= in_xmax;
              ymin_q  <= in_ymin;
              ymax_q  <= in_ymax;
              xe_q    <= X_1;
              ye_q    <= Y_1;
              edge_q  <= 2'd0;
              sx_q    <= (X_1 >= X_0);
              sy_q    <= (Y_1 >= Y_0);
              dx_q    <= in_dx;
              dy_q    <= in_dy;
              bres_q  <= in_dx + in_dy;
              busy_q  <= 1'b1;
              pv_q    <= 1'b1;
              if (in_kind == K_LINE || in_kind == K_POINT) begin
                x_q    <= X_0;
                y_q    <= Y_0;
                last_q <= (in_kind == K_POINT) || in_line_last;
              end else begin
                x_q    <= in_xmin;
                y_q    <= in_ymin;
                last_q <= in_rect_last;
              end
            end else begin
              state_q <= S_FIN;
              fin_q   <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ABORT) begin
            state_q <= S_IDLE;
            pv_q    <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end else if (PIX_READY) begin
            if (last_q) begin
              state_q <= S_FIN;
              pv_q    <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              fin_q   <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              x_q    <= nx;
              y_q    <= ny;
              edge_q <= ne;
              bres_q <= nbres;
              last_q <= nlast;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          fin_q   <= 1'b0;
          err_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_READY = rdy_q & ENB;
  assign PIX_VALID = pv_q & ENB;
  assign FINISH    = fin_q & ENB;
  assign X_OUT     = x_q;
  assign Y_OUT     = y_q;
  assign PIX_LAST  = last_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_draw_unit_gen.sv
// Self-checking bench for draw_unit_gen: directed table, corner sequences and
// random commands against a closed-form pixel-list model.
module tb_draw_unit_gen;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic rst_n, enb, abort, cmd_valid, cmd_ready, pix_valid, pix_ready;
  logic pix_last, busy, finish, err;
  logic [TW-1:0] typ;
  logic [CW-1:0] x0, y0, x1, y1, xo, yo;

  logic cv10, cr10, pv10, pr10, pl10, busy10, fin10, err10;
  logic [9:0] x0_10, y0_10, x1_10, y1_10, xo10, yo10;

  always #5 clk = ~clk;

  draw_unit_gen #(.CW(CW), .TW(TW)) dut (
    .ACLK(clk), .ARESETN(rst_n), .ENB(enb), .ABORT(abort),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .TYPE(typ),
    .X_0(x0), .Y_0(y0), .X_1(x1), .Y_1(y1),
    .PIX_VALID(pix_valid), .PIX_READY(pix_ready), .X_OUT(xo), .Y_OUT(yo),
    .PIX_LAST(pix_last), .BUSY(busy), .FINISH(finish), .ERR(err));

  draw_unit_gen #(.CW(10), .TW(TW)) dut10 (
    .ACLK(clk), .ARESETN(rst_n), .ENB(enb), .ABORT(abort),
    .CMD_VALID(cv10), .CMD_READY(cr10), .TYPE(typ),
    .X_0(x0_10), .Y_0(y0_10), .X_1(x1_10), .Y_1(y1_10),
    .PIX_VALID(pv10), .PIX_READY(pr10), .X_OUT(xo10), .Y_OUT(yo10),
    .PIX_LAST(pl10), .BUSY(busy10), .FINISH(fin10), .ERR(err10));

  int errors = 0;
  int checks = 0;
  int ex[$];
  int ey[$];

  typedef struct {
    int t, x0, y0, x1, y1, mode, n, lx, ly, err;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected pixel list straight from the primitive definitions
  function automatic void model(input int t, input int ax, input int ay, input int bx, input int by);
    int code, a, b, sx, sy, xmn, xmx, ymn, ymx;
    ex.delete();
    ey.delete();
    code = (t >> 2) & 63;
    if (code == 1) begin
      ex.push_back(ax); ey.push_back(ay);
    end else if (code == 0) begin
      a  = iabs(bx - ax);
      b  = iabs(by - ay);
      sx = (bx >= ax) ? 1 : -1;
      sy = (by >= ay) ? 1 : -1;
      if (a == 0 && b == 0) begin
        ex.push_back(ax); ey.push_back(ay);
      end else if (a >= b) begin
        for (int i = 0; i <= a; i++) begin
          ex.push_back(ax + sx * i);
          ey.push_back(ay + sy * ((2 * i * b + a) / (2 * a)));
        end
      end else begin
        for (int i = 0; i <= b; i++) begin
          ex.push_back(ax + sx * ((2 * i * a + b) / (2 * b)));
          ey.push_back(ay + sy * i);
        end
      end
    end else if (code == 2 || code == 3) begin
      xmn = (ax < bx) ? ax : bx;  xmx = (ax < bx) ? bx : ax;
      ymn = (ay < by) ? ay : by;  ymx = (ay < by) ? by : ay;
      if (code == 3 || xmn == xmx || ymn == ymx) begin
        for (int y = ymn; y <= ymx; y++)
          for (int x = xmn; x <= xmx; x++) begin
            ex.push_back(x); ey.push_back(y);
          end
      end else begin
        for (int x = xmn; x <= xmx; x++) begin ex.push_back(x); ey.push_back(ymn); end
        for (int y = ymn + 1; y <= ymx; y++) begin ex.push_back(xmx); ey.push_back(y); end
        for (int x = xmx - 1; x >= xmn; x--) begin ex.push_back(x); ey.push_back(ymx); end
        for (int y = ymx - 1; y > ymn; y--) begin ex.push_back(xmn); ey.push_back(y); end
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after accept
  task automatic start_cmd(input int t, input int ax, input int ay, input int bx, input int by);
    typ = TW'(t); x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by);
    cmd_valid = 1'b1;
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    typ = TW'($urandom); x0 = CW'($urandom); y0 = CW'($urandom);
    x1 = CW'($urandom); y1 = CW'($urandom);
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready, 3 random ready and enable
  task automatic run_cmd(input int t, input int ax, input int ay, input int bx, input int by,
                         input int mode, output int n_got, output int lx, output int ly,
                         output int errv);
    int idx, cyc, bound, px, py;
    model(t, ax, ay, bx, by);
    n_got = 0; lx = -1; ly = -1; errv = -1;
    pix_ready = (mode == 0) ? 1'b1 : 1'($urandom);
    start_cmd(t, ax, ay, bx, by);
    if (ex.size() == 0) begin
      chk("err_finish", 32'(finish), 1);
      chk("err_pix_valid", 32'(pix_valid), 0);
      errv = 32'(err);
      @(negedge clk);
      chk("err_finish_drop", 32'(finish), 0);
      chk("err_back_idle", 32'(cmd_ready), 1);
      return;
    end
    chk("first_valid", 32'(pix_valid), 1);
    chk("busy_run", 32'(busy), 1);
    chk("ready_low_run", 32'(cmd_ready), 0);
    idx = 0; cyc = 0; px = 32'(xo); py = 32'(yo);
    bound = 4 * ex.size() + 40;
    while (idx < ex.size() && cyc < bound) begin
      if (!enb) begin
        chk("frozen_valid", 32'(pix_valid), 0);
        chk("frozen_finish", 32'(finish), 0);
        chk("frozen_x", 32'(xo), px);
        chk("frozen_y", 32'(yo), py);
      end
      px = 32'(xo); py = 32'(yo);
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        2: pix_ready = 1'($urandom);
        default: begin
          pix_ready = 1'($urandom);
          enb = ($urandom_range(0, 3) != 0);
        end
      endcase
      #1;
      if (pix_valid) begin
        chk("pix_x", 32'(xo), ex[idx]);
        chk("pix_y", 32'(yo), ey[idx]);
        chk("pix_last", 32'(pix_last), (idx == ex.size() - 1) ? 1 : 0);
        if (pix_ready) begin
          lx = 32'(xo); ly = 32'(yo);
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_got = idx;
    if (idx != ex.size()) chk("pixel_timeout", idx, ex.size());
    enb = 1'b1;
    #1;
    chk("finish_pulse", 32'(finish), 1);
    chk("fin_pix_valid", 32'(pix_valid), 0);
    chk("fin_busy", 32'(busy), 0);
    errv = 32'(err);
    @(negedge clk);
    chk("finish_one_cycle", 32'(finish), 0);
    chk("ready_after_fin", 32'(cmd_ready), 1);
  endtask

  initial begin
    int n, lx, ly, ev, t, code, ax, ay, bx, by, mode;
    rst_n = 1'b0; enb = 1'b1; abort = 1'b0; cmd_valid = 1'b0; pix_ready = 1'b0;
    typ = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    cv10 = 1'b0; pr10 = 1'b0; x0_10 = '0; y0_10 = '0; x1_10 = '0; y1_10 = '0;

    tbl[0]  = '{8'h04,   5,   7,   0,   0, 0,    1,   5,   7, 0};
    tbl[1]  = '{8'h00,   0,   0,   4,   2, 0,    5,   4,   2, 0};
    tbl[2]  = '{8'h00,   4,   2,   0,   0, 0,    5,   0,   0, 0};
    tbl[3]  = '{8'h01,  10,  10,  14,  11, 3,    5,  14,  11, 0};
    tbl[4]  = '{8'h00,  10,  10,  11,  14, 0,    5,  11,  14, 0};
    tbl[5]  = '{8'h00,  10,  10,   9,  14, 2,    5,   9,  14, 0};
    tbl[6]  = '{8'h00,  10,  10,   6,  11, 3,    5,   6,  11, 0};
    tbl[7]  = '{8'h02,  10,  10,   6,   9, 0,    5,   6,   9, 0};
    tbl[8]  = '{8'h00,  10,  10,   9,   6, 1,    5,   9,   6, 0};
    tbl[9]  = '{8'h03,  10,  10,  11,   6, 0,    5,  11,   6, 0};
    tbl[10] = '{8'h00,  10,  10,  14,   9, 0,    5,  14,   9, 0};
    tbl[11] = '{8'h08,   3,   3,   1,   1, 1,    8,   1,   2, 0};
    tbl[12] = '{8'h08,   2,   5,   2,   8, 0,    4,   2,   8, 0};
    tbl[13] = '{8'h0C, 254, 254, 255, 255, 0,    4, 255, 255, 0};
    tbl[14] = '{8'h10,   1,   1,   2,   2, 0,    0,  -1,  -1, 1};
    tbl[15] = '{8'h08,   0,   0, 255, 255, 2, 1020,   0,   1, 0};
    tbl[16] = '{8'h07,   9,   3, 100, 100, 0,    1,   9,   3, 0};
    tbl[17] = '{8'h0F,   0,   0,   0,   0, 1,    1,   0,   0, 0};
    tbl[18] = '{8'hFC,   7,   7,   7,   7, 0,    0,  -1,  -1, 1};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_xy", 32'({xo, yo}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].t, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].mode, n, lx, ly, ev);
      chk($sformatf("tbl%0d_count", i), n, tbl[i].n);
      chk($sformatf("tbl%0d_last_x", i), lx, tbl[i].lx);
      chk($sformatf("tbl%0d_last_y", i), ly, tbl[i].ly);
      chk($sformatf("tbl%0d_err", i), ev, tbl[i].err);
    end

    // Abort on the third pixel of a fill; abort then ignored while idle
    pix_ready = 1'b1;
    start_cmd(8'h0C, 0, 0, 3, 3);
    @(negedge clk); @(negedge clk);
    chk("abort_third_x", 32'(xo), 2);
    chk("abort_third_y", 32'(yo), 0);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(pix_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_finish", 32'(finish), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    chk("abort_idle_finish", 32'(finish), 0);
    chk("abort_idle_ready", 32'(cmd_ready), 1);
    abort = 1'b0;

    // Asynchronous reset in the middle of a line
    start_cmd(8'h00, 0, 0, 20, 10);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(pix_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_last", 32'(pix_last), 0);
    chk("midrst_xy", 32'({xo, yo}), 0);
    chk("midrst_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(8'h00, 0, 0, 4, 2, 0, n, lx, ly, ev);
    chk("post_rst_count", n, 5);

    // Wide-coordinate instance at the top of its range
    typ = 8'h08; x0_10 = 10'd1020; y0_10 = 10'd0; x1_10 = 10'd1023; y1_10 = 10'd0;
    cv10 = 1'b1; pr10 = 1'b1;
    #1 chk("w10_ready", 32'(cr10), 1);
    @(negedge clk);
    cv10 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w10_valid", 32'(pv10), 1);
      chk("w10_x", 32'(xo10), 1020 + i);
      chk("w10_y", 32'(yo10), 0);
      chk("w10_last", 32'(pl10), (i == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("w10_finish", 32'(fin10), 1);
    chk("w10_err", 32'(err10), 0);
    @(negedge clk);

    // Random commands with random back-pressure and enable
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 9: code = 0;
        3:          code = 1;
        4, 5:       code = 2;
        6, 7:       code = 3;
        default:    code = $urandom_range(4, 63);
      endcase
      t = (code << 2) | $urandom_range(0, 3);
      if (code == 2 || code == 3) begin
        ax = $urandom_range(0, 243); ay = $urandom_range(0, 243);
        bx = ax + $urandom_range(0, 12); by = ay + $urandom_range(0, 12);
        if ($urandom_range(0, 1) != 0) begin int tmp = ax; ax = bx; bx = tmp; end
      end else begin
        ax = $urandom_range(0, 255); ay = $urandom_range(0, 255);
        bx = $urandom_range(0, 255); by = $urandom_range(0, 255);
      end
      mode = $urandom_range(0, 3);
      run_cmd(t, ax, ay, bx, by, mode, n, lx, ly, ev);
      chk("rnd_count", n, ex.size());
      chk("rnd_err", ev, (code > 3) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
